// File: rtl/md_unit_if.sv
// E-stage operand/opcode bundle into the multiply/divide unit and its HI/LO/handshake results.
interface md_unit_if;
    logic [31:0] A_E;
    logic [31:0] B_E;
    logic [2:0]  MD_Op_E;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output A_E, B_E, MD_Op_E, input Start, Busy, HI, LO);
    modport slave  (input A_E, B_E, MD_Op_E, output Start, Busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle mult/div with HI/LO; result lands MULT_CYCLES/DIV_CYCLES edges after issue.
// Never stalls: ops presented while Busy are dropped, so the hazard unit must hold them in D.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    md_unit_if.slave md
);
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] cnt;
    logic [31:0]   hi, lo, hi_tmp, lo_tmp;
    logic          busy, start, is_mul, is_div;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   quo, rem;

    assign busy   = (cnt != '0);
    assign is_mul = (md.MD_Op_E == OP_MULT) || (md.MD_Op_E == OP_MULTU);
    assign is_div = (md.MD_Op_E == OP_DIV)  || (md.MD_Op_E == OP_DIVU);
    assign start  = (is_mul || is_div) && reset && !busy;

    always_comb begin
        prod_s = $signed({{32{md.A_E[31]}}, md.A_E}) * $signed({{32{md.B_E[31]}}, md.B_E});
        prod_u = {32'b0, md.A_E} * {32'b0, md.B_E};
        quo    = '0;
        rem    = '0;
        if (md.B_E != '0) begin
            if (md.MD_Op_E == OP_DIV) begin
                // -2^31 / -1 overflows; MIPS leaves LO = dividend, HI = 0 with no trap.
                if (md.A_E == 32'h8000_0000 && md.B_E == 32'hFFFF_FFFF) begin
                    quo = 32'h8000_0000;
                    rem = '0;
                end else begin
                    quo = $signed(md.A_E) / $signed(md.B_E);
                    rem = $signed(md.A_E) % $signed(md.B_E);
                end
            end else begin
                quo = md.A_E / md.B_E;
                rem = md.A_E % md.B_E;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            hi_tmp <= '0;
            lo_tmp <= '0;
        end else if (busy) begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                hi <= hi_tmp;
                lo <= lo_tmp;
            end
        end else begin
            case (md.MD_Op_E)
                OP_MULT: begin
                    {hi_tmp, lo_tmp} <= prod_s;
                    cnt <= CW'(MULT_CYCLES);
                end
                OP_MULTU: begin
                    {hi_tmp, lo_tmp} <= prod_u;
                    cnt <= CW'(MULT_CYCLES);
                end
                OP_DIV, OP_DIVU: begin
                    if (md.B_E != '0) begin
                        hi_tmp <= rem;
                        lo_tmp <= quo;
                        cnt    <= CW'(DIV_CYCLES);
                    end
                end
                OP_MTHI: hi <= md.A_E;
                OP_MTLO: lo <= md.A_E;
                default: ;
            endcase
        end
    end

    assign md.Start = start;
    assign md.Busy  = busy;
    assign md.HI    = hi;
    assign md.LO    = lo;
endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [2:0] NONE  = 3'b000;
    localparam logic [2:0] MULT  = 3'b001;
    localparam logic [2:0] MULTU = 3'b010;
    localparam logic [2:0] DIV   = 3'b011;
    localparam logic [2:0] DIVU  = 3'b100;
    localparam logic [2:0] MTHI  = 3'b101;
    localparam logic [2:0] MTLO  = 3'b110;
    localparam logic [2:0] BAD   = 3'b111;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;   // >0 busy cycles, 0 dropped, -1 direct write / no-op
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_unit_if bus();
    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus.slave)
    );

    res_t        sb[$];
    vec_t        vt[12];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] prev_hi = 32'h0;
    logic [31:0] prev_lo = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.MD_Op_E = op;
        bus.A_E     = a;
        bus.B_E     = b;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.Busy && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic finish_op(input string name, input int exp_n);
        int   n;
        res_t r;
        wait_idle(n);
        check({name, " busy_cycles"}, 32'(n), 32'(exp_n));
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", name);
        end else begin
            r = sb.pop_front();
            check({name, " HI"}, bus.HI, r.hi);
            check({name, " LO"}, bus.LO, r.lo);
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        res_t r;
        logic exp_start;
        exp_start = (v.op >= MULT) && (v.op <= DIVU);
        drive(v.op, v.a, v.b);
        #1;
        check({name, " Start"}, {31'b0, bus.Start}, {31'b0, exp_start});
        if (v.cyc > 0) begin
            r.hi = v.hi;
            r.lo = v.lo;
            sb.push_back(r);
        end
        step();
        drive(NONE, 32'h0, 32'h0);
        if (v.cyc > 0) begin
            check({name, " HI_held"}, bus.HI, prev_hi);
            finish_op(name, v.cyc);
        end else begin
            check({name, " Busy"}, {31'b0, bus.Busy}, 32'h0);
            check({name, " HI"}, bus.HI, v.hi);
            check({name, " LO"}, bus.LO, v.lo);
        end
        prev_hi = v.hi;
        prev_lo = v.lo;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        vec_t v;

        vt[0]  = '{MULT,  32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, MC};
        vt[1]  = '{MULTU, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 32'hFFFF_FFFE, MC};
        vt[2]  = '{DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
        vt[3]  = '{DIV,   32'h7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DC};
        vt[4]  = '{DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        DC};
        vt[5]  = '{MULT,  32'h1_0000,    32'h1_0000,    32'h1,         32'h0,         MC};
        vt[6]  = '{MTHI,  32'h11,        32'h0,         32'h11,        32'h0,         -1};
        vt[7]  = '{MTLO,  32'h22,        32'h0,         32'h11,        32'h22,        -1};
        vt[8]  = '{DIVU,  32'd100,       32'h0,         32'h11,        32'h22,        0};
        vt[9]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, DC};
        vt[10] = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MC};
        vt[11] = '{BAD,   32'h5,         32'h5,         32'hFFFF_FFFE, 32'h0000_0001, -1};

        reset = 1'b0;
        drive(MULT, 32'h3, 32'h4);
        #12;
        check("reset Start", {31'b0, bus.Start}, 32'h0);
        check("reset Busy",  {31'b0, bus.Busy},  32'h0);
        check("reset HI",    bus.HI, 32'h0);
        check("reset LO",    bus.LO, 32'h0);
        drive(NONE, 32'h0, 32'h0);
        step();
        reset = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("vec%0d", i), vt[i]);
        end

        // Ops presented mid-operation are ignored.
        drive(MULT, 32'd3, 32'd4);
        #1;
        check("busy_ign Start_issue", {31'b0, bus.Start}, 32'h1);
        sb.push_back('{32'h0, 32'd12});
        step();
        drive(MTHI, 32'hDEAD, 32'h0);
        #1;
        check("busy_ign Start_mthi", {31'b0, bus.Start}, 32'h0);
        step();
        drive(MULT, 32'd5, 32'd5);
        #1;
        check("busy_ign Start_mult", {31'b0, bus.Start}, 32'h0);
        step();
        drive(NONE, 32'h0, 32'h0);
        finish_op("busy_ign", MC - 2);
        drive(MTLO, 32'hBEEF, 32'h0);
        #1;
        check("mtlo Start", {31'b0, bus.Start}, 32'h0);
        step();
        drive(NONE, 32'h0, 32'h0);
        check("mtlo LO",   bus.LO, 32'hBEEF);
        check("mtlo HI",   bus.HI, 32'h0);
        check("mtlo Busy", {31'b0, bus.Busy}, 32'h0);

        // Asynchronous reset in the middle of a divide.
        drive(DIV, 32'd20, 32'd3);
        step();
        drive(NONE, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) step();
        check("arst pre Busy", {31'b0, bus.Busy}, 32'h1);
        reset = 1'b0;
        #1;
        check("arst Busy", {31'b0, bus.Busy}, 32'h0);
        check("arst HI",   bus.HI, 32'h0);
        check("arst LO",   bus.LO, 32'h0);
        step();
        reset = 1'b1;
        prev_hi = 32'h0;
        prev_lo = 32'h0;
        v = '{MULTU, 32'd5, 32'd6, 32'h0, 32'd30, MC};
        run_vec("post_rst", v);

        // Op on the completion edge is ignored; accepted one cycle later.
        drive(MULT, 32'd2, 32'd3);
        step();
        drive(NONE, 32'h0, 32'h0);
        for (int i = 1; i < MC; i++) step();
        check("b2b last Busy", {31'b0, bus.Busy}, 32'h1);
        check("b2b last LO",   bus.LO, 32'd30);
        drive(MULT, 32'd7, 32'd7);
        #1;
        check("b2b Start_edge", {31'b0, bus.Start}, 32'h0);
        step();
        check("b2b done Busy", {31'b0, bus.Busy}, 32'h0);
        check("b2b done HI",   bus.HI, 32'h0);
        check("b2b done LO",   bus.LO, 32'd6);
        check("b2b Start_retry", {31'b0, bus.Start}, 32'h1);
        sb.push_back('{32'h0, 32'd49});
        step();
        drive(NONE, 32'h0, 32'h0);
        finish_op("b2b retry", MC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Execute-stage multiply/divide unit of the 5-stage MIPS pipeline.
- Consumes the forwarded E-stage operands: rs on A_E, rt on B_E, both taken after the ALU forwarding muxes.
- Holds the HI/LO architectural registers and runs mult/multu/div/divu over multiple cycles.
- Exports Start/Busy so the hazard unit can stall D-stage MD instructions (mult/div/mthi/mtlo/mfhi/mflo).

Parameters:
- MULT_CYCLES, 5, number of Busy cycles for mult/multu (legal range ≥1).
- DIV_CYCLES, 10, number of Busy cycles for div/divu (legal range ≥1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- A_E  input  32  forwarded rs operand of the E-stage instruction.
- B_E  input  32  forwarded rt operand of the E-stage instruction.
- MD_Op_E  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; 111 is treated as none.
- Start  output  1  combinational; 1 when MD_Op_E is 001..100, reset is deasserted and Busy=0.
- Busy  output  1  registered; 1 while an operation is in flight.
- HI  output  32  architectural HI register, used as the mfhi source.
- LO  output  32  architectural LO register, used as the mflo source.

Behaviour:
- Single clock domain, clk; reset is asynchronous, active-low.
- Reset (reset=0, at any time including mid-operation):
  - HI, LO, hi_tmp, lo_tmp and cnt are all 0; Busy=0.
  - Any in-flight operation is discarded.
  - Normal operation resumes on the first clk edge after reset returns to 1.
- Internal state:
  - hi_tmp/lo_tmp, 32b each: pending result.
  - cnt: down-counter, width ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)).
  - Busy = (cnt != 0).
- Issue: on a rising edge with Start=1:
  - mult: {hi_tmp,lo_tmp} <= $signed(A_E)*$signed(B_E), full 64b product; cnt <= MULT_CYCLES.
  - multu: same with an unsigned product; cnt <= MULT_CYCLES.
  - div: lo_tmp <= signed quotient, truncated toward zero; hi_tmp <= remainder with the sign of the dividend; cnt <= DIV_CYCLES.
  - divu: unsigned quotient to lo_tmp and remainder to hi_tmp; cnt <= DIV_CYCLES.
  - div with A_E=0x80000000, B_E=0xFFFFFFFF: LO result 0x80000000, HI result 0; no trap.
  - div/divu with B_E=0: the operation is dropped. cnt stays 0, Busy stays 0, HI/LO unchanged.
- Countdown: each edge with cnt != 0, cnt <= cnt-1. On the edge where cnt goes 1->0, HI <= hi_tmp and LO <= lo_tmp.
  - Busy is high for exactly N cycles after the issue edge (N = MULT_CYCLES or DIV_CYCLES).
  - HI/LO show the new value in the cycle Busy first reads 0.
  - HI/LO keep their old values throughout Busy.
- mthi/mtlo: on an edge with MD_Op_E=101/110 and Busy=0, HI <= A_E or LO <= A_E; visible next cycle. No Busy is generated.
- Ops while Busy=1: all MD_Op_E values are ignored.
  - No restart, no tmp overwrite, no mthi/mtlo write.
  - Start is forced to 0 while Busy=1.
  - The hazard unit must stall these ops; this block does not queue them.
- The op arriving on the same edge where cnt goes 1->0 sees Busy=1 and is ignored. The first accepted new op is on the following edge.
- The block never stalls or flushes itself. E-stage flush is the pipeline's responsibility: MD_Op_E must read 000 for bubbles.
- Timing: mfhi/mflo read HI/LO combinationally. The hazard unit guarantees no mfhi/mflo reaches E while Start|Busy=1.

Test Plan:
1. Reset → HI=LO=0, Busy=0. Then mult with A_E=0xFFFFFFFF, B_E=2 → Start=1 in the issue cycle, Busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
2. multu with A_E=0xFFFFFFFF, B_E=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE. div with A_E=0xFFFFFFF9 (-7), B_E=2 → Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. divu with A_E=100, B_E=0 after HI=0x11, LO=0x22 → Busy stays 0, HI/LO stay 0x11/0x22. div with 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
4. mult 3*4 issued, then mthi A_E=0xDEAD and a second mult presented during Busy → both ignored, Start=0; after completion HI=0, LO=12. mtlo A_E=0xBEEF with Busy=0 → LO=0xBEEF next cycle.
5. div issued, reset pulled low 4 cycles in → Busy, HI and LO immediately 0. After release, a new multu 5*6 completes with LO=30 after 5 cycles.
6. Back-to-back: a mult presented on the exact completion edge → ignored. Re-presented one cycle later → accepted, Busy high again for MULT_CYCLES.
